// File: rtl/bist_rtap_initiator.sv
// rtl/bist_rtap_initiator.sv - RTAP-side serial master for the SRAM wrapper BIST debug bus
`ifndef BIST_OP_WIDTH
`define BIST_OP_WIDTH 3
`endif
`ifndef BIST_OP_SHIFT_ID
`define BIST_OP_SHIFT_ID 1
`endif
`ifndef BIST_OP_SHIFT_BSEL
`define BIST_OP_SHIFT_BSEL 2
`endif
`ifndef BIST_OP_SHIFT_ADDRESS
`define BIST_OP_SHIFT_ADDRESS 3
`endif
`ifndef BIST_OP_READ
`define BIST_OP_READ 4
`endif
`ifndef BIST_OP_SHIFT_DATA
`define BIST_OP_SHIFT_DATA 5
`endif
`ifndef JTAG_DATA_REQ_WIDTH
`define JTAG_DATA_REQ_WIDTH 192
`endif
`ifndef JTAG_DATA_RES_WIDTH
`define JTAG_DATA_RES_WIDTH 256
`endif
`ifndef SRAM_WRAPPER_BUS_WIDTH
`define SRAM_WRAPPER_BUS_WIDTH 4
`endif

module bist_rtap_initiator #(
    parameter int GAP_CYCLES = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_write,
    input  logic [7:0]                           req_sram_id,
    input  logic [7:0]                           req_chunk_id,
    input  logic [15:0]                          req_addr,
    input  logic [`JTAG_DATA_REQ_WIDTH-1:0]      req_wdata,
    output logic                                 rsp_valid,
    output logic                                 rsp_write,
    output logic [`JTAG_DATA_RES_WIDTH-1:0]      rsp_rdata,
    output logic [`BIST_OP_WIDTH-1:0]            rtap_srams_bist_command,
    output logic [`SRAM_WRAPPER_BUS_WIDTH-1:0]   rtap_srams_bist_data,
    input  logic [`SRAM_WRAPPER_BUS_WIDTH-1:0]   srams_rtap_data
);

    localparam int CW = `BIST_OP_WIDTH;
    localparam logic [CW-1:0] OP_IDLE = '0;
    localparam logic [CW-1:0] OP_ID   = CW'(`BIST_OP_SHIFT_ID);
    localparam logic [CW-1:0] OP_BSEL = CW'(`BIST_OP_SHIFT_BSEL);
    localparam logic [CW-1:0] OP_ADDR = CW'(`BIST_OP_SHIFT_ADDRESS);
    localparam logic [CW-1:0] OP_READ = CW'(`BIST_OP_READ);
    localparam logic [CW-1:0] OP_DATA = CW'(`BIST_OP_SHIFT_DATA);

    // Gaps shorter than two idle commands would not let every wrapper settle.
    localparam int              GAP_EFF  = (GAP_CYCLES < 2) ? 2 : GAP_CYCLES;
    localparam logic [5:0]      GAP_LAST = 6'(GAP_EFF - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SHIFT_ID, S_SHIFT_BSEL, S_SHIFT_ADDR, S_ISSUE_READ, S_READ_WAIT,
        S_SHIFT_RDATA, S_SHIFT_WDATA, S_WRITE_WAIT, S_DONE, S_GAP
    } state_t;

    state_t         r_state;
    logic [5:0]     r_cnt;
    logic           r_write;
    logic [7:0]     r_id;
    logic [7:0]     r_chunk;
    logic [15:0]    r_addr;
    logic [191:0]   r_wdata;
    logic [251:0]   r_rshift;

    // Transaction sequencer: each field register shifts left so its top nibble is always the next one to issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state                 <= S_IDLE;
            r_cnt                   <= '0;
            r_write                 <= 1'b0;
            r_id                    <= '0;
            r_chunk                 <= '0;
            r_addr                  <= '0;
            r_wdata                 <= '0;
            r_rshift                <= '0;
            req_ready               <= 1'b1;
            rsp_valid               <= 1'b0;
            rsp_write               <= 1'b0;
            rsp_rdata               <= '0;
            rtap_srams_bist_command <= OP_IDLE;
            rtap_srams_bist_data    <= '0;
        end else begin
            r_cnt <= r_cnt + 6'd1;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (req_valid && req_ready) begin
                        r_write                 <= req_write;
                        r_id                    <= req_sram_id << 4;
                        r_chunk                 <= req_chunk_id;
                        r_addr                  <= req_addr;
                        r_wdata                 <= req_wdata;
                        req_ready               <= 1'b0;
                        r_state                 <= S_SHIFT_ID;
                        rtap_srams_bist_command <= OP_ID;
                        rtap_srams_bist_data    <= req_sram_id[7:4];
                    end
                end
                S_SHIFT_ID: begin
                    if (r_cnt == 6'd1) begin
                        r_cnt                   <= '0;
                        r_state                 <= S_SHIFT_BSEL;
                        rtap_srams_bist_command <= OP_BSEL;
                        rtap_srams_bist_data    <= r_chunk[7:4];
                        r_chunk                 <= r_chunk << 4;
                    end else begin
                        rtap_srams_bist_data    <= r_id[7:4];
                        r_id                    <= r_id << 4;
                    end
                end
                S_SHIFT_BSEL: begin
                    if (r_cnt == 6'd1) begin
                        r_cnt                   <= '0;
                        r_state                 <= S_SHIFT_ADDR;
                        rtap_srams_bist_command <= OP_ADDR;
                        rtap_srams_bist_data    <= r_addr[15:12];
                        r_addr                  <= r_addr << 4;
                    end else begin
                        rtap_srams_bist_data    <= r_chunk[7:4];
                        r_chunk                 <= r_chunk << 4;
                    end
                end
                S_SHIFT_ADDR: begin
                    if (r_cnt == 6'd3) begin
                        r_cnt <= '0;
                        if (r_write) begin
                            r_state                 <= S_SHIFT_WDATA;
                            rtap_srams_bist_command <= OP_DATA;
                            rtap_srams_bist_data    <= r_wdata[191:188];
                            r_wdata                 <= r_wdata << 4;
                        end else begin
                            r_state                 <= S_ISSUE_READ;
                            rtap_srams_bist_command <= OP_READ;
                            rtap_srams_bist_data    <= '0;
                        end
                    end else begin
                        rtap_srams_bist_data    <= r_addr[15:12];
                        r_addr                  <= r_addr << 4;
                    end
                end
                S_ISSUE_READ: begin
                    r_cnt                   <= '0;
                    r_state                 <= S_READ_WAIT;
                    rtap_srams_bist_command <= OP_IDLE;
                end
                S_READ_WAIT: begin
                    r_cnt                   <= '0;
                    r_state                 <= S_SHIFT_RDATA;
                    rtap_srams_bist_command <= OP_DATA;
                end
                S_SHIFT_RDATA: begin
                    // The wrapper drives nibble k combinationally while our k-th SHIFT_DATA is on the bus.
                    r_rshift <= {r_rshift[247:0], srams_rtap_data};
                    if (r_cnt == 6'd63) begin
                        r_cnt                   <= '0;
                        r_state                 <= S_DONE;
                        rtap_srams_bist_command <= OP_IDLE;
                        rsp_valid               <= 1'b1;
                        rsp_write               <= r_write;
                        rsp_rdata               <= {r_rshift, srams_rtap_data};
                    end
                end
                S_SHIFT_WDATA: begin
                    if (r_cnt == 6'd47) begin
                        r_cnt                   <= '0;
                        r_state                 <= S_WRITE_WAIT;
                        rtap_srams_bist_command <= OP_IDLE;
                        rtap_srams_bist_data    <= '0;
                    end else begin
                        rtap_srams_bist_data    <= r_wdata[191:188];
                        r_wdata                 <= r_wdata << 4;
                    end
                end
                S_WRITE_WAIT: begin
                    if (r_cnt == 6'd1) begin
                        r_cnt     <= '0;
                        r_state   <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_write <= r_write;
                    end
                end
                S_DONE: begin
                    r_cnt     <= '0;
                    r_state   <= S_GAP;
                    rsp_valid <= 1'b0;
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_cnt                   <= '0;
                    r_state                 <= S_IDLE;
                    req_ready               <= 1'b1;
                    rsp_valid               <= 1'b0;
                    rtap_srams_bist_command <= OP_IDLE;
                    rtap_srams_bist_data    <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/bist_rtap_initiator.md
Name: bist_rtap_initiator

Overview:
- RTAP-side master for the SRAM wrapper BIST debug bus.
- Accepts one read or write request at a time on a valid/ready port and serializes it as 4-bit nibbles on the shared command/data bus that feeds every SRAM wrapper.
- For reads, captures the 256-bit response nibble stream and returns it on a response port.
- Sits between the JTAG/RTAP register file and the broadcast `rtap_srams_bist_*` nets.

Parameters:
- GAP_CYCLES, 2, idle-command cycles driven after each transaction before req_ready re-asserts; values below 2 are treated as 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  initiator can accept a request
- req_write  in  1  1=write, 0=read
- req_sram_id  in  8  target SRAM ID
- req_chunk_id  in  8  target chunk ID (sent as BSEL)
- req_addr  in  16  SRAM address
- req_wdata  in  `JTAG_DATA_REQ_WIDTH (192)  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_write  out  1  echo of req_write for the completed transaction
- rsp_rdata  out  `JTAG_DATA_RES_WIDTH (256)  read data
- rtap_srams_bist_command  out  `BIST_OP_WIDTH  bus command
- rtap_srams_bist_data  out  `SRAM_WRAPPER_BUS_WIDTH (4)  bus nibble
- srams_rtap_data  in  `SRAM_WRAPPER_BUS_WIDTH (4)  returned nibble (combinational from wrapper)

Behaviour:
- **Reset (async, rst_n=0):**
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_write=0; rsp_rdata=0.
  - Command=all-zeros (idle command); bus data=0; nibble counter=0.
  - Reset mid-transaction abandons the transaction with no rsp_valid. Wrappers return to their own IDLE on the next non-matching command.
- **Request acceptance:**
  - A request is accepted on a cycle with req_valid & req_ready. All request fields are latched.
  - req_ready drops the next cycle.
- **Outputs:** all bus outputs are registered. One nibble is issued per cycle, MSB nibble first for every field.
- **States and per-cycle bus values:**
  - IDLE: command=0.
  - SHIFT_ID (2 cycles): `BIST_OP_SHIFT_ID`; data=sram_id[7:4], then [3:0].
  - SHIFT_BSEL (2 cycles): `BIST_OP_SHIFT_BSEL`; data=chunk_id[7:4], then [3:0].
  - SHIFT_ADDR (4 cycles): `BIST_OP_SHIFT_ADDRESS`; data=addr[15:12] … [3:0].
  - Read path:
    - ISSUE_READ (1 cycle): `BIST_OP_READ`; data=0.
    - READ_WAIT (1 cycle): command=0. The wrapper samples the SRAM in this cycle.
    - SHIFT_RDATA (64 cycles): `BIST_OP_SHIFT_DATA`; data=0. Each cycle, sample srams_rtap_data into a shift register (shift left 4, insert at LSB). Wrapper nibble 0 (bits 255:252) lands at the MSB.
  - Write path:
    - SHIFT_WDATA (48 cycles): `BIST_OP_SHIFT_DATA`; data=wdata[191:188] … [3:0].
    - WRITE_WAIT (2 cycles): command=0. These cover the wrapper's WRITE_SRAM cycle and its commit cycle.
  - DONE (1 cycle):
    - rsp_valid=1; rsp_write=latched write.
    - On reads, rsp_rdata is updated in the same cycle. On writes, rsp_rdata is unchanged.
  - GAP: GAP_CYCLES cycles with command=0, then IDLE with req_ready=1.
- **Capture timing:** sampling is aligned so that the nibble present on srams_rtap_data during the k-th SHIFT_RDATA cycle is wrapper nibble k (k=0..63). No extra pipeline is allowed on the return path.
- **Latency (accept cycle = cycle 0):**
  - Read: first bus nibble in cycle 1; rsp_valid in cycle 75; req_ready re-asserts in cycle 76+GAP_CYCLES.
  - Write: rsp_valid in cycle 59.
- **Counter:** a single 6-bit nibble counter is reused in each state. It wraps to 0 on every state exit; there is no overflow path.
- **No backpressure on rsp:** rsp_rdata holds its value until the next read completes.
- **Non-matching target:** ID or chunk mismatch is undetectable on this bus. The wrapper sits idle and returns 0 nibbles, so a read completes normally with rsp_rdata=0.
- **Request changes after acceptance:** req_* changes after acceptance are ignored.
- **Overlap:** a new req_valid while busy is held off by req_ready=0.

Test Plan:
1. Read, wrapper model SR_ID=8'h2A, chunk 8'h00, addr 16'h0013, memory word=64'hDEADBEEF_01234567 (DATA_WIDTH=64) -> command sequence ID×2 (2,A), BSEL×2 (0,0), ADDR×4 (0,0,1,3), READ, idle, SHIFT_DATA×64; rsp_valid in cycle 75; rsp_rdata[255:192]=64'hDEADBEEF_01234567, rest 0.
2. Write addr 16'h0005, wdata[63:0]=64'hA5A5_0000_FFFF_1234, then a read of the same address -> the read returns the written value; write rsp_valid in cycle 59 with rsp_write=1; exactly 48 SHIFT_DATA cycles observed.
3. Read with req_sram_id=8'h2B against a wrapper with SR_ID=8'h2A -> wrapper never asserts its BIST enable; rsp_valid still in cycle 75 with rsp_rdata=0.
4. Back-to-back req_valid held high for two requests with GAP_CYCLES=2 -> second acceptance exactly 3 cycles after the first rsp_valid; at least 2 zero-command cycles between transactions.
5. rst_n pulsed low during SHIFT_ADDR -> outputs return to reset values immediately (async); no rsp_valid; the next read completes correctly.
6. GAP_CYCLES=0 -> behaves as 2, per the gap requirement of test 4.
